// File: rtl/ula_pkg.sv
// ula_pkg: shared operation codes, FSM state type and default width for ula_multiciclo.
// Contents: ULA_LARGURA default width, OP_* codes used by the ALU-control decoder, estado_t.
// Macro ULA_MULDIV_EN: when undefined the CALCULA state is not part of estado_t.
package ula_pkg;

    localparam int ULA_LARGURA = 32;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd8;
    localparam logic [3:0] OP_BEQ = 4'd9;
    localparam logic [3:0] OP_BLT = 4'd10;
    localparam logic [3:0] OP_BGT = 4'd11;
    localparam logic [3:0] OP_BNE = 4'd12;
    localparam logic [3:0] OP_BGE = 4'd13;
    localparam logic [3:0] OP_BLE = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

`ifdef ULA_MULDIV_EN
    typedef enum logic [0:0] {OCIOSO, CALCULA} estado_t;
`else
    typedef enum logic [0:0] {OCIOSO} estado_t;
`endif

endpackage

// File: rtl/ula_muldiv_iter.sv
// ula_muldiv_iter: iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
// Ports: clk, rst_n (async active-low); start latches a, b and op (0 MUL, 1 DIV);
// lo/hi are the values after the current iteration (product low/high or quotient/remainder),
// valid when done is high on the last of ITER iterations.
module ula_muldiv_iter
    import ula_pkg::*;
#(
    parameter int LARGURA = ULA_LARGURA,
    parameter int ITER    = LARGURA
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic               op,
    output logic [LARGURA-1:0] lo,
    output logic [LARGURA-1:0] hi,
    output logic               done
);

    localparam int CW = $clog2(ITER);

    // r_hi/r_lo double as {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    logic [LARGURA-1:0] m, r_hi, r_lo;
    logic               div, run;
    logic [CW-1:0]      cnt;
    logic [LARGURA:0]   soma, desl;
    logic [LARGURA+1:0] dif;

    always_comb begin
        soma = {1'b0, r_hi} + (r_lo[0] ? {1'b0, m} : '0);
        desl = {r_hi, r_lo[LARGURA-1]};
        dif  = {1'b0, desl} - {2'b0, m};
        hi   = div ? (dif[LARGURA+1] ? desl[LARGURA-1:0] : dif[LARGURA-1:0]) : soma[LARGURA:1];
        lo   = div ? {r_lo[LARGURA-2:0], ~dif[LARGURA+1]} : {soma[0], r_lo[LARGURA-1:1]};
    end

    assign done = run && cnt == CW'(ITER - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    <= '0;
            r_hi <= '0;
            r_lo <= '0;
            div  <= 1'b0;
            run  <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            m    <= op ? b : a;
            r_hi <= '0;
            r_lo <= op ? a : b;
            div  <= op;
            run  <= 1'b1;
            cnt  <= '0;
        end else if (run) begin
            r_hi <= hi;
            r_lo <= lo;
            cnt  <= cnt + 1'b1;
            run  <= !done;
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: EX-stage ALU with single-cycle logic/arith/shift/branch ops and iterative MUL/DIV.
// Ports: clk, rst_n (async active-low); inicio requests an op on sinal_controle with a, b, shamt;
// resultado/resultado_hi/zero/overflow/erro are registered and held until the next completion;
// ocupado marks a MUL/DIV in progress; pronto pulses for one cycle when results update.
// Macro ULA_MULDIV_EN: compiles in the iterative engine; otherwise MUL/DIV return erro=1 at once.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int LARGURA = ULA_LARGURA,
    parameter int ITER    = LARGURA
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic [3:0]         sinal_controle,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic [4:0]         shamt,
    output logic [LARGURA-1:0] resultado,
    output logic [LARGURA-1:0] resultado_hi,
    output logic               zero,
    output logic               overflow,
    output logic               ocupado,
    output logic               pronto,
    output logic               erro
);

    if (ITER != LARGURA) begin : g_iter_chk
        $error("ITER must equal LARGURA");
    end

    logic [LARGURA-1:0] soma, dif, r_res, r_hi;
    logic               r_ovf, r_erro, r_br, r_cond, r_zero, aceita, esc;

    assign aceita = inicio && !ocupado;
    assign soma   = a + b;
    assign dif    = a - b;

`ifdef ULA_MULDIV_EN
    estado_t            estado, prox;
    logic               longa, fim, m_done;
    logic [LARGURA-1:0] m_lo, m_hi;

    // DIV by zero is resolved in one cycle, so only real divisions enter the engine
    assign longa   = sinal_controle == OP_MUL || (sinal_controle == OP_DIV && b != '0);
    assign ocupado = estado == CALCULA;
    assign fim     = ocupado && m_done;
    assign esc     = fim || (aceita && !longa);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox;
    end

    always_comb begin
        prox = estado;
        if (estado == OCIOSO && aceita && longa) prox = CALCULA;
        else if (fim) prox = OCIOSO;
    end

    ula_muldiv_iter #(.LARGURA(LARGURA), .ITER(ITER)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (aceita && longa),
        .a     (a),
        .b     (b),
        .op    (sinal_controle == OP_DIV),
        .lo    (m_lo),
        .hi    (m_hi),
        .done  (m_done)
    );
`else
    assign ocupado = 1'b0;
    assign esc     = aceita;
`endif

    always_comb begin
        r_res  = '0;
        r_hi   = '0;
        r_ovf  = 1'b0;
        r_erro = 1'b0;
        r_br   = 1'b0;
        r_cond = 1'b0;
        case (sinal_controle)
            OP_AND: r_res = a & b;
            OP_OR:  r_res = a | b;
            OP_ADD: begin
                r_res = soma;
                r_ovf = a[LARGURA-1] == b[LARGURA-1] && soma[LARGURA-1] != a[LARGURA-1];
            end
            OP_SUB: begin
                r_res = dif;
                r_ovf = a[LARGURA-1] != b[LARGURA-1] && dif[LARGURA-1] != a[LARGURA-1];
            end
`ifdef ULA_MULDIV_EN
            OP_MUL: ;
            OP_DIV: begin
                r_res  = '1;
                r_hi   = a;
                r_erro = 1'b1;
            end
`else
            OP_MUL, OP_DIV: r_erro = 1'b1;
`endif
            OP_SRL: r_res = b >> shamt;
            OP_SLL: r_res = b << shamt;
            OP_NOR: r_res = ~(a | b);
            OP_BEQ: begin r_res = dif; r_br = 1'b1; r_cond = a == b; end
            OP_BLT: begin r_res = dif; r_br = 1'b1; r_cond = $signed(a) <  $signed(b); end
            OP_BGT: begin r_res = dif; r_br = 1'b1; r_cond = $signed(a) >  $signed(b); end
            OP_BNE: begin r_res = dif; r_br = 1'b1; r_cond = a != b; end
            OP_BGE: begin r_res = dif; r_br = 1'b1; r_cond = $signed(a) >= $signed(b); end
            OP_BLE: begin r_res = dif; r_br = 1'b1; r_cond = $signed(a) <= $signed(b); end
            OP_NOP: begin r_br = 1'b1; r_cond = 1'b1; end
        endcase
`ifdef ULA_MULDIV_EN
        // completion of the engine never coincides with an acceptance, so it can override here
        if (fim) begin
            r_res  = m_lo;
            r_hi   = m_hi;
            r_ovf  = 1'b0;
            r_erro = 1'b0;
            r_br   = 1'b0;
        end
`endif
        r_zero = r_br ? r_cond : r_res == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultado    <= '0;
            resultado_hi <= '0;
            zero         <= 1'b0;
            overflow     <= 1'b0;
            erro         <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            pronto <= esc;
            if (esc) begin
                resultado    <= r_res;
                resultado_hi <= r_hi;
                zero         <= r_zero;
                overflow     <= r_ovf;
                erro         <= r_erro;
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: scoreboard bench for ula_multiciclo with directed cases and random operations.
module tb_ula_multiciclo;

    localparam int W    = 32;
    localparam int ITER = 32;

    logic         clk = 1'b0, rst_n = 1'b0, inicio = 1'b0;
    logic [3:0]   sinal_controle = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [4:0]   shamt = '0;
    logic [W-1:0] resultado, resultado_hi;
    logic         zero, overflow, ocupado, pronto, erro;

    typedef struct packed {
        logic [3:0]   c;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         ov;
        logic         er;
        int           due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0, cyc = 0;

    ula_multiciclo #(.LARGURA(W), .ITER(ITER)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inicio         (inicio),
        .sinal_controle (sinal_controle),
        .a              (a),
        .b              (b),
        .shamt          (shamt),
        .resultado      (resultado),
        .resultado_hi   (resultado_hi),
        .zero           (zero),
        .overflow       (overflow),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .erro           (erro)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_long(input logic [3:0] c, input logic [W-1:0] y);
`ifdef ULA_MULDIV_EN
        return c == 4'd4 || (c == 4'd5 && y != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] x, y, input logic [4:0] s);
        exp_t    e;
        longint  sx, sy;
        logic [63:0] p;
        e   = '0;
        e.c = c;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        p   = '0;
        case (c)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: begin e.res = x + y; e.ov = (sx + sy) != longint'($signed(e.res)); end
            4'd3: begin e.res = x - y; e.ov = (sx - sy) != longint'($signed(e.res)); end
            4'd4: begin
`ifdef ULA_MULDIV_EN
                p = {32'h0, x} * {32'h0, y};
                e.res = p[31:0];
                e.hi  = p[63:32];
`else
                e.er = 1'b1;
`endif
            end
            4'd5: begin
`ifdef ULA_MULDIV_EN
                if (y == 0) begin e.res = '1; e.hi = x; e.er = 1'b1; end
                else begin e.res = x / y; e.hi = x % y; end
`else
                e.er = 1'b1;
`endif
            end
            4'd6: e.res = y >> s;
            4'd7: e.res = y << s;
            4'd8: e.res = ~(x | y);
            4'd9:  begin e.res = x - y; e.z = x == y; end
            4'd10: begin e.res = x - y; e.z = sx < sy; end
            4'd11: begin e.res = x - y; e.z = sx > sy; end
            4'd12: begin e.res = x - y; e.z = x != y; end
            4'd13: begin e.res = x - y; e.z = sx >= sy; end
            4'd14: begin e.res = x - y; e.z = sx <= sy; end
            default: e.z = 1'b1;
        endcase
        if (c < 4'd9) e.z = e.res == 0;
        return e;
    endfunction

    // monitor: every pronto pulse must match the oldest outstanding expectation, on its due cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pronto) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pronto: got pronto with res=%h, required no pronto", resultado);
            end else begin
                e = q.pop_front();
                if ({resultado, resultado_hi, zero, overflow, erro} !== {e.res, e.hi, e.z, e.ov, e.er}) begin
                    n_err++;
                    $display("FAIL result code=%0d: got res=%h hi=%h z=%b ov=%b er=%b, required res=%h hi=%h z=%b ov=%b er=%b",
                             e.c, resultado, resultado_hi, zero, overflow, erro, e.res, e.hi, e.z, e.ov, e.er);
                end
                n_cmp++;
                if (cyc != e.due) begin
                    n_err++;
                    $display("FAIL latency code=%0d: got pronto at cycle %0d, required %0d", e.c, cyc, e.due);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [W-1:0] got, want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    // called at a negedge with ocupado low; returns at the negedge of the completion cycle
    task automatic issue(input logic [3:0] c, input logic [W-1:0] x, y, input logic [4:0] s);
        exp_t e;
        int   n;
        bit   lg;
        lg    = is_long(c, y);
        e     = model(c, x, y, s);
        e.due = cyc + 1 + (lg ? ITER : 0);
        q.push_back(e);
        inicio = 1'b1; sinal_controle = c; a = x; b = y; shamt = s;
        @(negedge clk);
        inicio = 1'b0; a = $urandom(); b = $urandom(); shamt = 5'($urandom());
        n = 0;
        while (ocupado && n < ITER + 4) begin
            inicio = 1'($urandom());
            sinal_controle = 4'($urandom());
            n++;
            @(negedge clk);
        end
        inicio = 1'b0;
        check("busy_cycles", W'(n), W'(lg ? ITER : 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", W'({resultado, resultado_hi, zero, overflow, ocupado, pronto, erro} != '0), '0);
        q.delete();
        inicio = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 20));
            1:       return 32'h7FFF_FFFF + W'($urandom_range(0, 2));
            2:       return W'(0 - $urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [W-1:0] x, y;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", W'({resultado, resultado_hi, zero, overflow, ocupado, pronto, erro} != '0), '0);

        issue(4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0);
        check("add_ovf_res", resultado, 32'h8000_0000);
        check("add_ovf_flag", W'(overflow), 1);
        issue(4'd10, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("blt_zero", W'(zero), 1);
        issue(4'd11, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("bgt_zero", W'(zero), 0);
        issue(4'd15, 32'h1234, 32'h5678, 5'd3);
        check("nop_zero", W'(zero), 1);
        issue(4'd4, 32'h1_0000, 32'h1_0000, 5'd0);
`ifdef ULA_MULDIV_EN
        check("mul_lo", resultado, 0);
        check("mul_hi", resultado_hi, 1);
`endif
        issue(4'd5, 32'd100, 32'd7, 5'd0);
`ifdef ULA_MULDIV_EN
        check("div_q", resultado, 14);
        check("div_r", resultado_hi, 2);
`endif
        issue(4'd5, 32'd5, 32'd0, 5'd0);
`ifdef ULA_MULDIV_EN
        check("div0_res", resultado, 32'hFFFF_FFFF);
        check("div0_hi", resultado_hi, 5);
`endif
        check("div0_erro", W'(erro), 1);

        @(negedge clk);
`ifdef ULA_MULDIV_EN
        inicio = 1'b1; sinal_controle = 4'd5; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        inicio = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy", W'(ocupado), 1);
`endif
        do_reset();
        repeat (ITER + 4) @(negedge clk);
        issue(4'd7, 32'h0, 32'h1, 5'd4);
        check("sll_after_reset", resultado, 16);

        for (int i = 0; i < 400; i++) begin
            x = rnd_op();
            y = ($urandom_range(0, 3) == 0) ? x : rnd_op();
            if ($urandom_range(0, 9) == 0) y = '0;
            issue(4'($urandom_range(0, 15)), x, y, 5'($urandom()));
        end

        repeat (ITER + 4) @(negedge clk);
        check("pending_results", W'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
